// File: rtl/instr_fetch.sv
// Fetch stage: walks the program counter through ROM and collects an opcode plus up to
// two extension words, then presents the whole instruction to the decoder.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] MDB_out,
    input  logic        instr_ready,
    input  logic        branch_en,
    input  logic [15:0] branch_target,
    output logic [15:0] MAB_out,
    output logic        fetch_en,
    output logic [15:0] pc_out,
    output logic [15:0] instr_pc,
    output logic [15:0] IR,
    output logic [15:0] ext_src,
    output logic [15:0] ext_dst,
    output logic [1:0]  n_ext,
    output logic        illegal,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        S_OP   = 2'd0,
        S_SRC  = 2'd1,
        S_DST  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] ext_src_q, ext_src_d;
    logic [15:0] ext_dst_q, ext_dst_d;
    logic [15:0] instr_pc_q, instr_pc_d;
    logic [1:0]  n_ext_q, n_ext_d;
    logic        illegal_q, illegal_d;
    logic        instr_valid_q, instr_valid_d;
    logic        need_dst_q, need_dst_d;
    logic        dec_src, dec_dst, dec_ill;

    // R2 with As=10/11 and R3 with any As are constant generators and take no word
    function automatic logic src_word(input logic [1:0] as_m, input logic [3:0] rs);
        return (as_m == 2'b01 && rs != 4'd3) || (as_m == 2'b11 && rs == 4'd0);
    endfunction

    // Returns {illegal, need_src, need_dst}
    function automatic logic [2:0] decode_op(input logic [15:0] w);
        logic ns, nd, ill;
        ns  = 1'b0;
        nd  = 1'b0;
        ill = 1'b0;
        if (w[15:12] >= 4'd4) begin
            ns = src_word(w[5:4], w[11:8]);
            nd = w[7];
        end else if (w[15:10] == 6'b000100) begin
            ns  = src_word(w[5:4], w[3:0]);
            ill = (w[9:7] == 3'b111);
        end else if (w[15:13] != 3'b001) begin
            ill = 1'b1;
        end
        return {ill, ns, nd};
    endfunction

    assign {dec_ill, dec_src, dec_dst} = decode_op(MDB_out);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_OP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_OP: begin
                if (dec_src)      state_d = S_SRC;
                else if (dec_dst) state_d = S_DST;
                else              state_d = S_HOLD;
            end
            S_SRC:   state_d = need_dst_q ? S_DST : S_HOLD;
            S_DST:   state_d = S_HOLD;
            S_HOLD:  if (instr_ready) state_d = S_OP;
            default: state_d = S_OP;
        endcase
        if (branch_en) state_d = S_OP;
    end

    always_comb begin
        fetch_en      = (state_q != S_HOLD);
        pc_d          = pc_q;
        ir_d          = ir_q;
        ext_src_d     = ext_src_q;
        ext_dst_d     = ext_dst_q;
        instr_pc_d    = instr_pc_q;
        n_ext_d       = n_ext_q;
        illegal_d     = illegal_q;
        need_dst_d    = need_dst_q;
        instr_valid_d = (state_d == S_HOLD);
        if (branch_en) begin
            // the word on MDB this cycle is dropped and the pointer reloaded instead
            pc_d = branch_target & 16'hFFFE;
        end else if (fetch_en) begin
            pc_d = pc_q + 16'd2;
            case (state_q)
                S_OP: begin
                    ir_d       = MDB_out;
                    instr_pc_d = pc_q;
                    ext_src_d  = 16'h0000;
                    ext_dst_d  = 16'h0000;
                    n_ext_d    = {1'b0, dec_src} + {1'b0, dec_dst};
                    illegal_d  = dec_ill;
                    need_dst_d = dec_dst;
                end
                S_SRC:   ext_src_d = MDB_out;
                S_DST:   ext_dst_d = MDB_out;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC & 16'hFFFE;
            ir_q          <= 16'h0000;
            ext_src_q     <= 16'h0000;
            ext_dst_q     <= 16'h0000;
            instr_pc_q    <= 16'h0000;
            n_ext_q       <= 2'd0;
            illegal_q     <= 1'b0;
            instr_valid_q <= 1'b0;
            need_dst_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            ir_q          <= ir_d;
            ext_src_q     <= ext_src_d;
            ext_dst_q     <= ext_dst_d;
            instr_pc_q    <= instr_pc_d;
            n_ext_q       <= n_ext_d;
            illegal_q     <= illegal_d;
            instr_valid_q <= instr_valid_d;
            need_dst_q    <= need_dst_d;
        end
    end

    assign MAB_out     = pc_q;
    assign pc_out      = pc_q;
    assign instr_pc    = instr_pc_q;
    assign IR          = ir_q;
    assign ext_src     = ext_src_q;
    assign ext_dst     = ext_dst_q;
    assign n_ext       = n_ext_q;
    assign illegal     = illegal_q;
    assign instr_valid = instr_valid_q;

endmodule
